load_store_unit: RTL and testbench

Memory-side partner of the CPU ALU. It takes the effective address and register operand that the ALU produces for load/store opcodes and runs one transaction on the Avalon-style data bus. It generates byte enables and lane-shifted write data. For loads, it extracts, sign-extends or zero-extends the returned word and presents the result for write-back to `rt`. It sits between the ALU and the data-memory bus, and the CPU control FSM stalls on `busy_o`.

---
 rtl/codes_pkg.sv | 23 ++
 rtl/lsu_lane_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 115 +++++++++++
 tb/tb_load_store_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/codes_pkg.sv
// Shared CPU codes: operand width, load/store opcodes and the LSU state encoding.
package codes;

  typedef logic [31:0] size_t;

  typedef enum logic [5:0] {
    OP_LB  = 6'h20,
    OP_LH  = 6'h21,
    OP_LW  = 6'h23,
    OP_LBU = 6'h24,
    OP_LHU = 6'h25,
    OP_SB  = 6'h28,
    OP_SH  = 6'h29,
    OP_SW  = 6'h2B
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit: byte enables, replicated store
// data, load extraction/extension and the alignment check. Purely combinational.
module lsu_lane_align import codes::*; (
  input  opcode_t     opcode,
  input  logic [1:0]  offset,
  input  size_t       store_data,
  input  size_t       read_data,
  output logic [3:0]  byteenable,
  output size_t       writedata,
  output size_t       load_data,
  output logic        misaligned,
  output logic        is_load,
  output logic        is_store
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Decode access size, steer lanes and extend the returned datum.
  always_comb begin
    byteenable = 4'b0000;
    writedata  = '0;
    load_data  = '0;
    misaligned = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    byte_lane  = read_data[{offset, 3'b000} +: 8];
    half_lane  = offset[1] ? read_data[31:16] : read_data[15:0];

    case (opcode)
      OP_LB, OP_LBU, OP_SB: begin
        byteenable = 4'b0001 << offset;
        writedata  = {4{store_data[7:0]}};
        load_data  = (opcode == OP_LB) ? {{24{byte_lane[7]}}, byte_lane}
                                        : {24'h0, byte_lane};
        is_load    = (opcode != OP_SB);
        is_store   = (opcode == OP_SB);
      end
      OP_LH, OP_LHU, OP_SH: begin
        byteenable = 4'b0011 << offset;
        writedata  = {2{store_data[15:0]}};
        load_data  = (opcode == OP_LH) ? {{16{half_lane[15]}}, half_lane}
                                        : {16'h0, half_lane};
        misaligned = offset[0];
        is_load    = (opcode != OP_SH);
        is_store   = (opcode == OP_SH);
      end
      OP_LW, OP_SW: begin
        byteenable = 4'b1111;
        writedata  = store_data;
        load_data  = read_data;
        misaligned = (offset != 2'b00);
        is_load    = (opcode == OP_LW);
        is_store   = (opcode == OP_SW);
      end
      default: begin
        // Unknown opcodes complete like a misaligned access, with no bus cycle.
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: runs one Avalon-style data-bus transaction per start and
// returns the extended load result. All outputs are registered.
module load_store_unit import codes::*; (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        start_i,
  input  opcode_t     opcode_i,
  input  size_t       effective_address_i,
  input  size_t       store_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        misaligned_o,
  output size_t       load_data_o,
  output size_t       avm_address_o,
  output logic        avm_read_o,
  output logic        avm_write_o,
  output logic [3:0]  avm_byteenable_o,
  output size_t       avm_writedata_o,
  input  logic        avm_waitrequest_i,
  input  size_t       avm_readdata_i
);

  lsu_state_t state_q, state_d;
  opcode_t    op_q;
  size_t      addr_q, sdata_q;

  opcode_t    op_sel;
  size_t      addr_sel, sdata_sel;

  logic [3:0] lane_be;
  size_t      lane_wd, lane_ld;
  logic       lane_misaligned, lane_is_load, lane_is_store;

  // In IDLE the lane logic looks at the incoming request so the bus outputs
  // can be registered on the start edge; afterwards it uses the latched copy.
  assign op_sel    = (state_q == IDLE) ? opcode_i            : op_q;
  assign addr_sel  = (state_q == IDLE) ? effective_address_i : addr_q;
  assign sdata_sel = (state_q == IDLE) ? store_data_i        : sdata_q;

  lsu_lane_align u_lane (
    .opcode     (op_sel),
    .offset     (addr_sel[1:0]),
    .store_data (sdata_sel),
    .read_data  (avm_readdata_i),
    .byteenable (lane_be),
    .writedata  (lane_wd),
    .load_data  (lane_ld),
    .misaligned (lane_misaligned),
    .is_load    (lane_is_load),
    .is_store   (lane_is_store)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Request capture; holds the transaction steady for the whole access.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start_i) begin
      op_q    <= opcode_i;
      addr_q  <= effective_address_i;
      sdata_q <= store_data_i;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = lane_misaligned ? DONE : ACCESS;
      ACCESS:  if (!avm_waitrequest_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      misaligned_o     <= 1'b0;
      load_data_o      <= '0;
      avm_address_o    <= '0;
      avm_read_o       <= 1'b0;
      avm_write_o      <= 1'b0;
      avm_byteenable_o <= 4'b0000;
      avm_writedata_o  <= '0;
    end else begin
      busy_o       <= (state_d != IDLE);
      done_o       <= (state_d == DONE);
      misaligned_o <= (state_q == IDLE) && start_i && lane_misaligned;

      if (state_d == ACCESS) begin
        avm_read_o       <= lane_is_load;
        avm_write_o      <= lane_is_store;
        avm_address_o    <= {addr_sel[31:2], 2'b00};
        avm_byteenable_o <= lane_be;
        avm_writedata_o  <= lane_is_store ? lane_wd : '0;
      end else begin
        avm_read_o       <= 1'b0;
        avm_write_o      <= 1'b0;
        avm_address_o    <= '0;
        avm_byteenable_o <= 4'b0000;
        avm_writedata_o  <= '0;
      end

      if (state_q == ACCESS && lane_is_load && !avm_waitrequest_i)
        load_data_o <= lane_ld;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard testbench for load_store_unit.
module tb_load_store_unit;
  import codes::*;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        start_i;
  opcode_t     opcode_i;
  size_t       effective_address_i;
  size_t       store_data_i;
  logic        busy_o, done_o, misaligned_o;
  size_t       load_data_o;
  size_t       avm_address_o;
  logic        avm_read_o, avm_write_o;
  logic [3:0]  avm_byteenable_o;
  size_t       avm_writedata_o;
  logic        avm_waitrequest_i;
  size_t       avm_readdata_i;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk                 (clk),
    .reset_i             (reset_i),
    .start_i             (start_i),
    .opcode_i            (opcode_i),
    .effective_address_i (effective_address_i),
    .store_data_i        (store_data_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .misaligned_o        (misaligned_o),
    .load_data_o         (load_data_o),
    .avm_address_o       (avm_address_o),
    .avm_read_o          (avm_read_o),
    .avm_write_o         (avm_write_o),
    .avm_byteenable_o    (avm_byteenable_o),
    .avm_writedata_o     (avm_writedata_o),
    .avm_waitrequest_i   (avm_waitrequest_i),
    .avm_readdata_i      (avm_readdata_i)
  );

  typedef struct {
    logic        mis;
    logic [31:0] load;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          n_txn  = 0;
  logic [31:0] model_load_q = '0;

  // Values captured from the most recent run_op for explicit spot checks.
  logic [31:0] spot_addr, spot_wd;
  logic [3:0]  spot_be;
  int          spot_lat, spot_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model.
  function automatic int op_bytes(input opcode_t op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit op_is_load(input opcode_t op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic logic [3:0] model_be(input int n, input int o);
    int v;
    v = ((1 << n) - 1) << o;
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wd(input int n, input logic [31:0] sd);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_ld(input opcode_t op, input int o, input logic [31:0] rd);
    logic [31:0] r;
    r = rd >> (8 * o);
    case (op)
      OP_LB:   return {{24{r[7]}}, r[7:0]};
      OP_LBU:  return {24'h0, r[7:0]};
      OP_LH:   return {{16{r[15]}}, r[15:0]};
      OP_LHU:  return {16'h0, r[15:0]};
      default: return r;
    endcase
  endfunction

  // Completion monitor: every done_o pops one expectation.
  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      n_done++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("misaligned", {31'h0, misaligned_o}, {31'h0, mon_e.mis});
        chk("load_data", load_data_o, mon_e.load);
      end
    end else if (misaligned_o !== 1'b0) begin
      chk("mis_without_done", {31'h0, misaligned_o}, 32'd0);
    end
  end

  // One transaction with a simple slave; dup pulses start while busy and in the done cycle.
  task automatic run_op(input opcode_t op, input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rd, input int waits, input bit dup);
    int   n, o, nstrobe, lat;
    bit   mis;
    exp_t e;
    n = op_bytes(op);
    o = int'(addr[1:0]);
    if (n == 0) mis = 1'b1;
    else        mis = (o % n) != 0;
    nstrobe = 0;
    lat     = 0;
    spot_addr = '0; spot_wd = '0; spot_be = '0;
    @(negedge clk);
    if (op_is_load(op) && !mis) model_load_q = model_ld(op, o, rd);
    e.mis  = mis;
    e.load = model_load_q;
    sb_q.push_back(e);
    n_txn++;
    start_i = 1'b1; opcode_i = op; effective_address_i = addr;
    store_data_i = sd; avm_readdata_i = rd; avm_waitrequest_i = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 20 && lat == 0; cyc++) begin
      @(negedge clk);
      start_i = dup && (cyc == 1);
      if (dup && cyc == 1) begin
        opcode_i = OP_SW; effective_address_i = 32'h0000_4000;
      end
      if (cyc == 1) chk("busy_first", {31'h0, busy_o}, 32'd1);
      if (avm_read_o || avm_write_o) begin
        chk("strobe_kind", {30'h0, avm_read_o, avm_write_o}, op_is_load(op) ? 32'd2 : 32'd1);
        chk("address", avm_address_o, {addr[31:2], 2'b00});
        chk("byteenable", {28'h0, avm_byteenable_o}, {28'h0, model_be(n, o)});
        if (!op_is_load(op)) chk("writedata", avm_writedata_o, model_wd(n, sd));
        if (nstrobe == 0) begin
          spot_addr = avm_address_o; spot_be = avm_byteenable_o; spot_wd = avm_writedata_o;
        end
        avm_waitrequest_i = (nstrobe < waits);
        nstrobe++;
      end
      if (done_o) begin
        lat = cyc;
        chk("busy_at_done", {31'h0, busy_o}, 32'd1);
        chk("strobe_at_done", {30'h0, avm_read_o, avm_write_o}, 32'd0);
        if (dup) start_i = 1'b1;
      end
    end
    if (lat == 0) chk("done_timeout", 32'd0, 32'd1);
    chk("latency", lat, mis ? 32'd1 : 32'(2 + waits));
    chk("strobe_cycles", nstrobe, mis ? 32'd0 : 32'(waits + 1));
    spot_lat = lat;
    spot_n   = nstrobe;
    @(negedge clk);
    start_i = 1'b0;
    avm_waitrequest_i = 1'b0;
    chk("busy_after", {31'h0, busy_o}, 32'd0);
    @(negedge clk);
    chk("idle_after", {27'h0, avm_read_o, avm_write_o, busy_o, done_o, misaligned_o}, 32'd0);
  endtask

  opcode_t rnd_ops[8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

  initial begin
    int done_before;
    reset_i = 1'b0; start_i = 1'b0; opcode_i = OP_LW;
    effective_address_i = '0; store_data_i = '0;
    avm_waitrequest_i = 1'b0; avm_readdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {27'h0, busy_o, done_o, misaligned_o, avm_read_o, avm_write_o}, 32'd0);
    chk("rst_be", {28'h0, avm_byteenable_o}, 32'd0);
    chk("rst_addr", avm_address_o, 32'd0);
    chk("rst_wd", avm_writedata_o, 32'd0);
    chk("rst_load", load_data_o, 32'd0);
    reset_i = 1'b1;

    run_op(OP_LW, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 2, 1'b0);
    chk("lw_data", load_data_o, 32'hDEAD_BEEF);
    chk("lw_latency", spot_lat, 32'd4);
    chk("lw_read_cycles", spot_n, 32'd3);

    run_op(OP_LB, 32'h0000_1003, 32'h0, 32'h8011_2233, 0, 1'b0);
    chk("lb_be", {28'h0, spot_be}, 32'h8);
    chk("lb_data", load_data_o, 32'hFFFF_FF80);
    run_op(OP_LBU, 32'h0000_1003, 32'h0, 32'h8011_2233, 0, 1'b0);
    chk("lbu_data", load_data_o, 32'h0000_0080);

    run_op(OP_SH, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 0, 1'b0);
    chk("sh_addr", spot_addr, 32'h0000_2000);
    chk("sh_be", {28'h0, spot_be}, 32'hC);
    chk("sh_wd", spot_wd, 32'hABCD_ABCD);
    chk("sh_latency", spot_lat, 32'd2);

    run_op(OP_SW, 32'h0000_3001, 32'h1234_5678, 32'h0, 0, 1'b0);
    chk("sw_mis_latency", spot_lat, 32'd1);
    chk("sw_mis_writes", spot_n, 32'd0);
    chk("sw_mis_keeps_load", load_data_o, 32'h0000_0080);

    run_op(opcode_t'(6'h3F), 32'h0000_3000, 32'h0, 32'h0, 0, 1'b0);
    run_op(OP_LH, 32'h0000_1001, 32'h0, 32'h8001_7FFF, 0, 1'b0);
    run_op(OP_LH, 32'h0000_1002, 32'h0, 32'h8001_7FFF, 1, 1'b0);
    chk("lh_data", load_data_o, 32'hFFFF_8001);
    run_op(OP_LHU, 32'h0000_1000, 32'h0, 32'h8001_F00F, 0, 1'b0);
    chk("lhu_data", load_data_o, 32'h0000_F00F);
    run_op(OP_SB, 32'h0000_2001, 32'h0000_005A, 32'h0, 1, 1'b0);
    chk("sb_wd", spot_wd, 32'h5A5A_5A5A);

    done_before = n_done;
    run_op(OP_LW, 32'h0000_6000, 32'h0, 32'h1234_5678, 1, 1'b1);
    chk("busy_start_one_done", n_done - done_before, 32'd1);
    chk("busy_start_one_txn", spot_n, 32'd2);

    // Reset while the read strobe is held by waitrequest.
    @(negedge clk);
    start_i = 1'b1; opcode_i = OP_LW; effective_address_i = 32'h0000_5000;
    avm_waitrequest_i = 1'b1; avm_readdata_i = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    chk("rmid_read_on", {31'h0, avm_read_o}, 32'd1);
    @(negedge clk);
    chk("rmid_busy_on", {31'h0, busy_o}, 32'd1);
    reset_i = 1'b0;
    @(negedge clk);
    chk("rmid_after", {29'h0, avm_read_o, busy_o, done_o}, 32'd0);
    chk("rmid_load_cleared", load_data_o, 32'd0);
    reset_i = 1'b1;
    avm_waitrequest_i = 1'b0;
    model_load_q = '0;
    repeat (2) @(negedge clk);
    chk("rmid_no_done", {31'h0, done_o}, 32'd0);
    run_op(OP_LW, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
    chk("rmid_recover", load_data_o, 32'hCAFE_F00D);

    for (int k = 0; k < 12; k++) begin
      run_op(rnd_ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
             int'($urandom_range(0, 2)), 1'b0);
    end

    chk("done_count", n_done, n_txn);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
